// File: rtl/psum_accum_drain_if.sv
// Handshake bundle between the output FIFO, the accumulate/drain stage and the SRAM-bound stream.
//   fifo_out   : FIFO head row, lane i = bits [(i+1)*Bw-1 : i*Bw]
//   fifo_valid : FIFO has a full row
//   fifo_rd    : one-cycle pop request to the FIFO
//   out_data   : finished row, lane i = bits [(i+1)*AccBw-1 : i*AccBw]
//   out_valid  : out_data valid
//   out_ready  : downstream accepts out_data
// master = the drain stage, slave = its environment (FIFO + sink).
interface psum_accum_drain_if #(
  parameter int unsigned Col   = 8,
  parameter int unsigned Bw    = 16,
  parameter int unsigned AccBw = 20
);
  logic [Col*Bw-1:0]    fifo_out;
  logic                 fifo_valid;
  logic                 fifo_rd;
  logic [Col*AccBw-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    input  fifo_out,
    input  fifo_valid,
    input  out_ready,
    output fifo_rd,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_out,
    output fifo_valid,
    output out_ready,
    input  fifo_rd,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/psum_accum_drain.sv
// Consumer stage behind the output FIFO. Pops one row of partial sums per request, accumulates
// rows across weight passes in a local buffer and, on the final pass, streams each finished row
// (optionally ReLU-clamped) out on a valid/ready interface.
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   start      : start a job (sampled in idle only)
//   num_rows   : rows per pass, latched at start
//   num_passes : passes to accumulate (1..16), latched at start
//   relu_en    : clamp negative lanes to zero on output, latched at start
//   bus        : FIFO pop side and output stream (see psum_accum_drain_if)
//   busy       : job in progress
//   done       : one-cycle pulse at job completion
module psum_accum_drain #(
  parameter int unsigned Col   = 8,
  parameter int unsigned Bw    = 16,
  parameter int unsigned AccBw = 20,
  parameter int unsigned Depth = 16,
  parameter int unsigned RowBw = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [RowBw-1:0]   num_rows,
  input  logic [4:0]         num_passes,
  input  logic               relu_en,
  psum_accum_drain_if.master bus,
  output logic               busy,
  output logic               done
);

  localparam int unsigned IdxBw = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StReq  = 3'd1;
  localparam logic [2:0] StWait = 3'd2;
  localparam logic [2:0] StCap  = 3'd3;
  localparam logic [2:0] StEmit = 3'd4;
  localparam logic [2:0] StFin  = 3'd5;

  localparam logic [RowBw-1:0] RowOne  = RowBw'(1);
  localparam logic [4:0]       PassOne = 5'd1;

  logic [2:0]       state_q, state_d;
  logic [RowBw-1:0] row_cnt_q, row_cnt_d;
  logic [4:0]       pass_cnt_q, pass_cnt_d;
  logic [RowBw-1:0] num_rows_q, num_rows_d;
  logic [4:0]       num_passes_q, num_passes_d;
  logic             relu_q, relu_d;

  // Accumulation buffer: one packed row of Col lanes per entry; contents need no reset.
  logic [Col*AccBw-1:0] acc_mem [Depth];
  logic [Col*AccBw-1:0] acc_rd;
  logic [Col*AccBw-1:0] acc_wdata;
  logic [Col*AccBw-1:0] out_row;
  logic                 acc_we;
  logic [IdxBw-1:0]     row_idx;

  logic last_row;
  logic last_pass;

  assign row_idx   = row_cnt_q[IdxBw-1:0];
  assign acc_rd    = acc_mem[row_idx];
  assign last_row  = (row_cnt_q == (num_rows_q - RowOne));
  assign last_pass = (pass_cnt_q == (num_passes_q - PassOne));

  // Lane datapath: accumulate the FIFO head into the current row, and form the ReLU'd output.
  always_comb begin
    acc_wdata = '0;
    out_row   = '0;
    for (int i = 0; i < int'(Col); i++) begin
      logic [AccBw-1:0] base;
      logic [AccBw-1:0] ext;
      logic [AccBw-1:0] cur;
      // First pass overwrites whatever stale data the buffer row holds.
      base = (pass_cnt_q == 5'd0) ? '0 : acc_rd[i*AccBw +: AccBw];
      ext  = AccBw'($signed(bus.fifo_out[i*Bw +: Bw]));
      acc_wdata[i*AccBw +: AccBw] = base + ext;
      cur = acc_rd[i*AccBw +: AccBw];
      out_row[i*AccBw +: AccBw] = (relu_q && cur[AccBw-1]) ? '0 : cur;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    row_cnt_d    = row_cnt_q;
    pass_cnt_d   = pass_cnt_q;
    num_rows_d   = num_rows_q;
    num_passes_d = num_passes_q;
    relu_d       = relu_q;
    acc_we       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          num_rows_d   = num_rows;
          num_passes_d = num_passes;
          relu_d       = relu_en;
          row_cnt_d    = '0;
          pass_cnt_d   = '0;
          state_d      = ((num_rows == '0) || (num_passes == 5'd0)) ? StFin : StReq;
        end
      end
      StReq: begin
        if (bus.fifo_valid) begin
          state_d = StWait;
        end
      end
      // Covers the FIFO's registered read enable so the head row is settled for capture.
      StWait: begin
        state_d = StCap;
      end
      StCap: begin
        acc_we = 1'b1;
        if (last_pass) begin
          state_d = StEmit;
        end else begin
          if (last_row) begin
            row_cnt_d  = '0;
            pass_cnt_d = pass_cnt_q + PassOne;
          end else begin
            row_cnt_d = row_cnt_q + RowOne;
          end
          state_d = StReq;
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          if (last_row) begin
            row_cnt_d  = '0;
            pass_cnt_d = pass_cnt_q + PassOne;
          end else begin
            row_cnt_d = row_cnt_q + RowOne;
          end
          state_d = (last_row && last_pass) ? StFin : StReq;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      row_cnt_q    <= '0;
      pass_cnt_q   <= '0;
      num_rows_q   <= '0;
      num_passes_q <= '0;
      relu_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_cnt_q    <= row_cnt_d;
      pass_cnt_q   <= pass_cnt_d;
      num_rows_q   <= num_rows_d;
      num_passes_q <= num_passes_d;
      relu_q       <= relu_d;
    end
  end

  always_ff @(posedge clk) begin
    if (acc_we) begin
      acc_mem[row_idx] <= acc_wdata;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them at once.
  assign bus.fifo_rd   = (state_q == StReq) && bus.fifo_valid;
  assign bus.out_valid = (state_q == StEmit);
  assign bus.out_data  = (state_q == StEmit) ? out_row : '0;
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StFin);

endmodule
